snn_axil_cfg_slave: RTL and testbench

AXI4-Lite responder that terminates host configuration traffic for the SNN core. It decodes the control, sim-time, memory-config and debug registers, plus a 256-entry external-memory window, and drives a generic single-port memory access bus. Downstream logic uses `MEM_CFG` to select spike-generator, synapse, spike-pattern or spike-counter memory. It sits between the AXI interconnect and the SNN core controller.

---
 rtl/snn_axil_cfg_slave.sv | 232 +++++++++++++++++++++++
 tb/tb_snn_axil_cfg_slave.sv | 331 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/snn_axil_cfg_slave.sv
// AXI4-Lite configuration slave for the SNN core.
// Purpose: decodes CTRL (0x0000), SIM_TIME (0x0004), MEM_CFG (0x0008),
//   DEBUG (0x000C, RO) and a 256-word external-memory window at
//   EXT_MEM_OFFSET. The window drives a shared single-port memory bus.
// Ports:
//   S_AXI_ACLK / S_AXI_ARESETN : clock, async active-low reset
//   S_AXI_AW*, S_AXI_W*, S_AXI_B* : AXI4-Lite write channels
//   S_AXI_AR*, S_AXI_R*           : AXI4-Lite read channels
//   busy                          : core running (blocks MEM_CFG/window writes)
//   ctrl_reg, sim_time_reg, mem_cfg_reg : register contents
//   start                         : one-cycle pulse on CTRL write with bit0=1
//   mem_addr/mem_wdata/mem_we/mem_re/mem_rdata : memory window bus
// Build option: define SNN_CFG_WSTRB_EN to merge register writes per byte
//   using WSTRB and reject partial window writes.
module snn_axil_cfg_slave #(
    parameter int          C_S_AXI_DATA_WIDTH = 32,
    parameter int          C_S_AXI_ADDR_WIDTH = 16,
    parameter logic [15:0] EXT_MEM_OFFSET     = 16'h0100
) (
    input  logic                            S_AXI_ACLK,
    input  logic                            S_AXI_ARESETN,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
    input  logic                            S_AXI_AWVALID,
    output logic                            S_AXI_AWREADY,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
    input  logic                            S_AXI_WVALID,
    output logic                            S_AXI_WREADY,
    output logic [1:0]                      S_AXI_BRESP,
    output logic                            S_AXI_BVALID,
    input  logic                            S_AXI_BREADY,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
    input  logic                            S_AXI_ARVALID,
    output logic                            S_AXI_ARREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
    output logic [1:0]                      S_AXI_RRESP,
    output logic                            S_AXI_RVALID,
    input  logic                            S_AXI_RREADY,
    input  logic                            busy,
    output logic [31:0]                     ctrl_reg,
    output logic [31:0]                     sim_time_reg,
    output logic [31:0]                     mem_cfg_reg,
    output logic                            start,
    output logic [7:0]                      mem_addr,
    output logic [31:0]                     mem_wdata,
    output logic                            mem_we,
    output logic                            mem_re,
    input  logic [31:0]                     mem_rdata
);

    localparam int AW = C_S_AXI_ADDR_WIDTH;
    localparam logic [AW-1:0] A_CTRL = AW'(16'h0000);
    localparam logic [AW-1:0] A_SIM  = AW'(16'h0004);
    localparam logic [AW-1:0] A_CFG  = AW'(16'h0008);
    localparam logic [AW-1:0] A_DBG  = AW'(16'h000C);
    localparam logic [AW-1:0] WIN_LO = AW'(EXT_MEM_OFFSET);
    localparam logic [AW-1:0] WIN_HI = AW'(EXT_MEM_OFFSET + 16'h00FF);
    localparam logic [1:0]    OKAY   = 2'b00;
    localparam logic [1:0]    SLVERR = 2'b10;

    typedef enum logic [1:0] {W_IDLE, W_ACK, W_RESP} w_state_t;
    typedef enum logic [1:0] {R_IDLE, R_ACK, R_WAIT, R_DATA} r_state_t;

    w_state_t w_state, w_next;
    r_state_t r_state, r_next;

    logic          wa_ctrl, wa_sim, wa_cfg, wa_win;
    logic          w_err, w_fire, w_apply;
    logic [31:0]   ctrl_nx, sim_nx, cfg_nx;
    logic          start_bit;
    logic [1:0]    bresp_q;

    logic [AW-1:0] araddr_q;
    logic          ra_ctrl, ra_sim, ra_cfg, ra_dbg, ra_win, ra_map;
    logic          r_stall;
    logic [31:0]   rd_val, rdata_q;
    logic [1:0]    rresp_q;

    logic [7:0]    err_cnt;
    logic [1:0]    err_inc;
    logic [8:0]    err_sum;

    // ---------------- write address decode ----------------
    // AW/W stay valid until the W_ACK handshake, so they are decoded live.
    assign wa_ctrl = (S_AXI_AWADDR == A_CTRL);
    assign wa_sim  = (S_AXI_AWADDR == A_SIM);
    assign wa_cfg  = (S_AXI_AWADDR == A_CFG);
    assign wa_win  = (S_AXI_AWADDR >= WIN_LO) && (S_AXI_AWADDR <= WIN_HI);

    // DEBUG is read-only, so it falls into the not-writable set.
    always_comb begin
        w_err = !(wa_ctrl | wa_sim | wa_cfg | wa_win)
              | (busy & (wa_win | wa_cfg));
`ifdef SNN_CFG_WSTRB_EN
        w_err = w_err | (wa_win & (S_AXI_WSTRB != '1));
`endif
    end

    assign w_fire  = (w_state == W_ACK);
    assign w_apply = w_fire & ~w_err;

    always_comb begin
        ctrl_nx   = S_AXI_WDATA;
        sim_nx    = S_AXI_WDATA;
        cfg_nx    = S_AXI_WDATA;
        start_bit = S_AXI_WDATA[0];
`ifdef SNN_CFG_WSTRB_EN
        for (int b = 0; b < 4; b++) begin
            if (!S_AXI_WSTRB[b]) begin
                ctrl_nx[8*b +: 8] = ctrl_reg[8*b +: 8];
                sim_nx[8*b +: 8]  = sim_time_reg[8*b +: 8];
                cfg_nx[8*b +: 8]  = mem_cfg_reg[8*b +: 8];
            end
        end
        start_bit = S_AXI_WDATA[0] & S_AXI_WSTRB[0];
`endif
    end

`ifndef SNN_CFG_WSTRB_EN
    logic unused_wstrb;
    assign unused_wstrb = ^S_AXI_WSTRB;
`endif

    // ---------------- write FSM ----------------
    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) w_state <= W_IDLE;
        else                w_state <= w_next;
    end

    always_comb begin
        w_next = w_state;
        unique case (w_state)
            W_IDLE:  if (S_AXI_AWVALID && S_AXI_WVALID) w_next = W_ACK;
            W_ACK:   w_next = W_RESP;
            W_RESP:  if (S_AXI_BREADY) w_next = W_IDLE;
            default: w_next = W_IDLE;
        endcase
    end

    always_comb begin
        S_AXI_AWREADY = (w_state == W_ACK);
        S_AXI_WREADY  = (w_state == W_ACK);
        S_AXI_BVALID  = (w_state == W_RESP);
    end

    // ---------------- shared memory port ----------------
    // A window write owns the port; a colliding window read waits in R_ACK.
    assign mem_we    = w_apply & wa_win;
    assign mem_wdata = S_AXI_WDATA;
    assign mem_addr  = mem_we ? S_AXI_AWADDR[7:0] : araddr_q[7:0];

    // ---------------- read address decode ----------------
    assign ra_ctrl = (araddr_q == A_CTRL);
    assign ra_sim  = (araddr_q == A_SIM);
    assign ra_cfg  = (araddr_q == A_CFG);
    assign ra_dbg  = (araddr_q == A_DBG);
    assign ra_win  = (araddr_q >= WIN_LO) && (araddr_q <= WIN_HI);
    assign ra_map  = ra_ctrl | ra_sim | ra_cfg | ra_dbg | ra_win;
    assign r_stall = ra_win & mem_we;

    // ---------------- read FSM ----------------
    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) r_state <= R_IDLE;
        else                r_state <= r_next;
    end

    always_comb begin
        r_next = r_state;
        unique case (r_state)
            R_IDLE:  if (S_AXI_ARVALID) r_next = R_ACK;
            R_ACK:   if (!r_stall) r_next = R_WAIT;
            R_WAIT:  r_next = R_DATA;
            R_DATA:  if (S_AXI_RREADY) r_next = R_IDLE;
            default: r_next = R_IDLE;
        endcase
    end

    always_comb begin
        S_AXI_ARREADY = (r_state == R_ACK) & ~r_stall;
        S_AXI_RVALID  = (r_state == R_DATA);
        mem_re        = (r_state == R_ACK) & ~r_stall & ra_win;
    end

    always_comb begin
        rd_val = '0;
        unique case (1'b1)
            ra_win:  rd_val = mem_rdata;
            ra_ctrl: rd_val = ctrl_reg;
            ra_sim:  rd_val = sim_time_reg;
            ra_cfg:  rd_val = mem_cfg_reg;
            ra_dbg:  rd_val = {16'h0, err_cnt, 7'h0, busy};
            default: rd_val = '0;
        endcase
    end

    // A write and a read can both fail in one cycle, so count up to 2.
    assign err_inc = {1'b0, w_fire & w_err}
                   + {1'b0, S_AXI_ARREADY & ~ra_map};
    assign err_sum = {1'b0, err_cnt} + {7'b0, err_inc};

    // ---------------- datapath registers ----------------
    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            ctrl_reg     <= '0;
            sim_time_reg <= '0;
            mem_cfg_reg  <= '0;
            start        <= 1'b0;
            bresp_q      <= OKAY;
            araddr_q     <= '0;
            rdata_q      <= '0;
            rresp_q      <= OKAY;
            err_cnt      <= '0;
        end else begin
            start <= w_apply & wa_ctrl & start_bit & ~busy;
            if (w_apply & wa_ctrl) ctrl_reg     <= ctrl_nx;
            if (w_apply & wa_sim)  sim_time_reg <= sim_nx;
            if (w_apply & wa_cfg)  mem_cfg_reg  <= cfg_nx;
            if (w_fire) bresp_q <= w_err ? SLVERR : OKAY;
            if (r_state == R_IDLE && S_AXI_ARVALID) araddr_q <= S_AXI_ARADDR;
            if (r_state == R_WAIT) begin
                rdata_q <= rd_val;
                rresp_q <= ra_map ? OKAY : SLVERR;
            end
            err_cnt <= err_sum[8] ? 8'hFF : err_sum[7:0];
        end
    end

    assign S_AXI_BRESP = bresp_q;
    assign S_AXI_RDATA = rdata_q;
    assign S_AXI_RRESP = rresp_q;

endmodule

// File: tb/tb_snn_axil_cfg_slave.sv
// Self-checking bench for snn_axil_cfg_slave.
// Behavioural register/window model plus per-cycle register compare.
module tb_snn_axil_cfg_slave;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] awaddr = '0;
    logic        awvalid = 1'b0;
    logic        awready;
    logic [31:0] wdata = '0;
    logic [3:0]  wstrb = 4'hF;
    logic        wvalid = 1'b0;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready = 1'b0;
    logic [15:0] araddr = '0;
    logic        arvalid = 1'b0;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready = 1'b0;
    logic        busy = 1'b0;
    logic [31:0] ctrl_reg, sim_time_reg, mem_cfg_reg;
    logic        start;
    logic [7:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_we, mem_re;
    logic [31:0] mem_rdata = '0;

    always #5 clk = ~clk;

    snn_axil_cfg_slave dut (
        .S_AXI_ACLK    (clk),
        .S_AXI_ARESETN (rst_n),
        .S_AXI_AWADDR  (awaddr),
        .S_AXI_AWVALID (awvalid),
        .S_AXI_AWREADY (awready),
        .S_AXI_WDATA   (wdata),
        .S_AXI_WSTRB   (wstrb),
        .S_AXI_WVALID  (wvalid),
        .S_AXI_WREADY  (wready),
        .S_AXI_BRESP   (bresp),
        .S_AXI_BVALID  (bvalid),
        .S_AXI_BREADY  (bready),
        .S_AXI_ARADDR  (araddr),
        .S_AXI_ARVALID (arvalid),
        .S_AXI_ARREADY (arready),
        .S_AXI_RDATA   (rdata),
        .S_AXI_RRESP   (rresp),
        .S_AXI_RVALID  (rvalid),
        .S_AXI_RREADY  (rready),
        .busy          (busy),
        .ctrl_reg      (ctrl_reg),
        .sim_time_reg  (sim_time_reg),
        .mem_cfg_reg   (mem_cfg_reg),
        .start         (start),
        .mem_addr      (mem_addr),
        .mem_wdata     (mem_wdata),
        .mem_we        (mem_we),
        .mem_re        (mem_re),
        .mem_rdata     (mem_rdata)
    );

    // external memory stub: read data one cycle after mem_re
    logic [31:0] mem [256] = '{default: 32'h0};
    always @(posedge clk) begin
        if (mem_we) mem[mem_addr] <= mem_wdata;
        if (mem_re) mem_rdata <= mem[mem_addr];
    end

    // behavioural model
    logic [31:0] m_ctrl = '0, m_sim = '0, m_cfg = '0;
    int          m_err = 0;
    logic [31:0] m_win [256] = '{default: 32'h0};

    int start_cnt = 0, we_cnt = 0, re_cnt = 0;
    always @(posedge clk) begin
        if (start)  start_cnt <= start_cnt + 1;
        if (mem_we) we_cnt <= we_cnt + 1;
        if (mem_re) re_cnt <= re_cnt + 1;
    end

    int n_chk = 0, n_pass = 0;
    bit chk_on = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp)
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        else
            n_pass++;
    endtask

    function automatic bit in_win(input logic [15:0] a);
        return (a >= 16'h0100) && (a <= 16'h01FF);
    endfunction

    function automatic bit mapped(input logic [15:0] a);
        return a == 16'h0 || a == 16'h4 || a == 16'h8 || a == 16'hC || in_win(a);
    endfunction

    function automatic bit wr_err(input logic [15:0] a, input bit bz);
        return !mapped(a) || a == 16'hC || (bz && (in_win(a) || a == 16'h8));
    endfunction

    function automatic void bump_err();
        if (m_err < 255) m_err = m_err + 1;
    endfunction

    // compare process: register outputs and port exclusion every cycle
    always @(negedge clk) begin
        if (rst_n && chk_on) begin
            chk("ctrl_reg", ctrl_reg, m_ctrl);
            chk("sim_time_reg", sim_time_reg, m_sim);
            chk("mem_cfg_reg", mem_cfg_reg, m_cfg);
            chk("we_re_excl", {31'b0, mem_we & mem_re}, 32'h0);
        end
    end

    task automatic axi_write(input logic [15:0] a, input logic [31:0] d);
        int  n, s0, w0;
        bit  err, exp_start, exp_we;
        err = wr_err(a, busy);
        exp_start = !err && a == 16'h0 && d[0] && !busy;
        exp_we = !err && in_win(a);
        s0 = start_cnt;
        w0 = we_cnt;
        @(negedge clk);
        awaddr = a; wdata = d; awvalid = 1; wvalid = 1; bready = 1;
        n = 0;
        do begin @(negedge clk); n++; end while (!awready && n < 8);
        chk("aw_latency", n, 1);
        chk("wready", {31'b0, wready}, 32'h1);
        chk("mem_we", {31'b0, mem_we}, {31'b0, exp_we});
        if (exp_we) begin
            chk("mem_addr", {24'b0, mem_addr}, {24'b0, a[7:0]});
            chk("mem_wdata", mem_wdata, d);
        end
        @(posedge clk); #1;
        awvalid = 0; wvalid = 0;
        if (err) bump_err();
        else if (a == 16'h0) m_ctrl = d;
        else if (a == 16'h4) m_sim = d;
        else if (a == 16'h8) m_cfg = d;
        else m_win[a[7:0]] = d;
        @(negedge clk);
        chk("bvalid", {31'b0, bvalid}, 32'h1);
        chk("bresp", {30'b0, bresp}, err ? 32'h2 : 32'h0);
        @(negedge clk);
        chk("bvalid_clr", {31'b0, bvalid}, 32'h0);
        chk("start_pulses", start_cnt - s0, {31'b0, exp_start});
        chk("we_pulses", we_cnt - w0, {31'b0, exp_we});
    endtask

    task automatic axi_read(input logic [15:0] a, input int hold,
                            output logic [31:0] got);
        int          n, r0;
        bit          seen_ar;
        logic [31:0] ed;
        logic [1:0]  er;
        er = mapped(a) ? 2'b00 : 2'b10;
        if (!mapped(a))     ed = 32'h0;
        else if (in_win(a)) ed = m_win[a[7:0]];
        else if (a == 16'h0) ed = m_ctrl;
        else if (a == 16'h4) ed = m_sim;
        else if (a == 16'h8) ed = m_cfg;
        else ed = {16'h0, 8'(m_err), 7'h0, busy};
        r0 = re_cnt;
        @(negedge clk);
        araddr = a; arvalid = 1; rready = (hold == 0);
        n = 0; seen_ar = 0;
        do begin
            @(negedge clk); n++;
            if (seen_ar) arvalid = 0;
            if (arready) seen_ar = 1;
        end while (!rvalid && n < 12);
        arvalid = 0;
        chk("r_latency", n, 3);
        chk("rdata", rdata, ed);
        chk("rresp", {30'b0, rresp}, {30'b0, er});
        chk("re_pulses", re_cnt - r0, {31'b0, in_win(a)});
        got = rdata;
        if (!mapped(a)) bump_err();
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            chk("rvalid_hold", {31'b0, rvalid}, 32'h1);
            chk("rdata_stable", rdata, ed);
        end
        rready = 1;
        @(negedge clk);
        chk("rvalid_clr", {31'b0, rvalid}, 32'h0);
    endtask

    // write + read to the same window word launched together
    task automatic simul(input logic [15:0] a, input logic [31:0] d);
        int we_at, re_at, b_at, r_at, b_hi;
        bit aw_seen, ar_seen;
        we_at = -1; re_at = -1; b_at = -1; r_at = -1; b_hi = 0;
        aw_seen = 0; ar_seen = 0;
        m_win[a[7:0]] = d;
        @(negedge clk);
        awaddr = a; wdata = d; araddr = a;
        awvalid = 1; wvalid = 1; arvalid = 1; bready = 0; rready = 1;
        for (int n = 1; n <= 14; n++) begin
            @(negedge clk);
            if (aw_seen) begin awvalid = 0; wvalid = 0; end
            if (ar_seen) arvalid = 0;
            if (awready) aw_seen = 1;
            if (arready) ar_seen = 1;
            if (mem_we && we_at < 0) we_at = n;
            if (mem_re && re_at < 0) re_at = n;
            if (rvalid && r_at < 0) begin
                r_at = n;
                chk("col_rdata", rdata, d);
                chk("col_rresp", {30'b0, rresp}, 32'h0);
            end
            if (bvalid) begin
                b_hi++;
                if (b_at < 0) begin
                    b_at = n;
                    chk("col_bresp", {30'b0, bresp}, 32'h0);
                end
                if (n - b_at >= 5) bready = 1;
            end
        end
        awvalid = 0; wvalid = 0; arvalid = 0; bready = 1;
        chk("col_we_cycle", we_at, 1);
        chk("col_re_cycle", re_at, 2);
        chk("col_rvalid_cycle", r_at, 4);
        chk("col_bvalid_cycle", b_at, 2);
        chk("col_bvalid_held", b_hi, 6);
    endtask

    function automatic logic [15:0] pick_addr();
        case ($urandom_range(0, 5))
            0: return 16'h0000;
            1: return 16'h0004;
            2: return 16'h0008;
            3: return 16'h000C;
            4: return 16'h0100 | 16'($urandom_range(0, 255));
            default: return 16'h0200 + 16'($urandom_range(0, 16'hFDFF));
        endcase
    endfunction

    logic [31:0] got;
    int          n;

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_awready", {31'b0, awready}, 32'h0);
        chk("rst_bvalid", {31'b0, bvalid}, 32'h0);
        chk("rst_arready", {31'b0, arready}, 32'h0);
        chk("rst_rvalid", {31'b0, rvalid}, 32'h0);
        chk("rst_start", {31'b0, start}, 32'h0);
        chk("rst_mem_we", {31'b0, mem_we}, 32'h0);
        chk("rst_mem_re", {31'b0, mem_re}, 32'h0);
        chk("rst_ctrl", ctrl_reg, 32'h0);
        chk("rst_rdata", rdata, 32'h0);
        chk("rst_resp", {28'b0, bresp, rresp}, 32'h0);
        rst_n = 1;
        chk_on = 1;

        axi_write(16'h0000, 32'hDEADBEEF);
        axi_read(16'h0000, 0, got);
        chk("lit_ctrl", got, 32'hDEADBEEF);

        axi_write(16'h0008, 32'h1);
        axi_write(16'h0105, 32'h7);
        axi_read(16'h0105, 0, got);
        chk("lit_win", got, 32'h7);

        busy = 1;
        axi_write(16'h0100, 32'h55);
        axi_read(16'h000C, 0, got);
        chk("lit_debug", got, 32'h101);
        busy = 0;

        axi_read(16'h0010, 0, got);
        chk("lit_unmapped", got, 32'h0);
        axi_write(16'h000C, 32'h1234);

        simul(16'h0142, 32'hCAFEF00D);
        axi_read(16'h0142, 1, got);

        for (int i = 0; i < 80; i++) begin
            logic [15:0] a;
            busy = ($urandom_range(0, 3) == 0);
            a = pick_addr();
            if ($urandom_range(0, 1) == 1) axi_write(a, $urandom());
            else axi_read(a, $urandom_range(0, 2), got);
        end
        busy = 0;

        for (int i = 0; i < 260; i++) axi_write(16'h0300, 32'(i));
        axi_read(16'h000C, 0, got);
        chk("lit_err_sat", {24'b0, got[15:8]}, 32'hFF);

        // reset while a read response is pending
        @(negedge clk);
        araddr = 16'h0004; arvalid = 1; rready = 0;
        n = 0;
        do begin
            @(negedge clk); n++;
            if (n == 2) arvalid = 0;
        end while (!rvalid && n < 10);
        arvalid = 0;
        chk("pre_rst_rvalid", {31'b0, rvalid}, 32'h1);
        #2;
        rst_n = 0;
        m_ctrl = '0; m_sim = '0; m_cfg = '0; m_err = 0;
        #1;
        chk("async_rst_rvalid", {31'b0, rvalid}, 32'h0);
        chk("async_rst_ctrl", ctrl_reg, 32'h0);
        rready = 1;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1;
        axi_read(16'h0004, 0, got);
        axi_write(16'h0004, 32'h0000_ABCD);
        axi_read(16'h0004, 0, got);
        chk("lit_post_rst", got, 32'h0000_ABCD);

        repeat (2) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
